// File: rtl/eltwise_stream_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : eltwise_stream_unit_if
// Purpose  : Stream bundle for the element-wise engine: operand stream A,
//            operand stream B and the result stream O (valid/ready/data,
//            plus o_last on the result stream).
// Ports    : a_valid/a_ready/a_data   operand A stream
//            b_valid/b_ready/b_data   operand B stream
//            o_valid/o_ready/o_data   result stream, o_last = final job beat
// Modports : master - the stream environment (sources A/B, sinks O)
//            slave  - the engine (sinks A/B, sources O)
// Revision : 1.0 - initial release
// ============================================================================
interface eltwise_stream_unit_if #(
    parameter int TOUT = 32,
    parameter int DW   = 16
);
    logic                 a_valid;
    logic                 a_ready;
    logic [TOUT*DW-1:0]   a_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [TOUT*DW-1:0]   b_data;
    logic                 o_valid;
    logic                 o_ready;
    logic [TOUT*DW-1:0]   o_data;
    logic                 o_last;

    modport master (
        output a_valid, a_data, b_valid, b_data, o_ready,
        input  a_ready, b_ready, o_valid, o_data, o_last
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, o_ready,
        output a_ready, b_ready, o_valid, o_data, o_last
    );
endinterface
`default_nettype wire

// File: rtl/eltwise_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : eltwise_stream_unit
// Purpose  : Streaming element-wise engine. Combines operand stream A with
//            operand stream B, TOUT signed lanes per beat, over
//            num_pix x ch_beats beats. Modes add/sub/mul/max/min with signed
//            saturation; B may be element-wise, a latched scalar, or a
//            per-channel beat held in an internal buffer.
// Ports    : clk, rst            clock, synchronous active-high reset
//            start               one-cycle job start, samples the config
//            mode                0 add, 1 sub, 2 mul, 3 max, 4 min
//            b_bcast             0 element-wise, 1 scalar, 2 per-channel
//            num_pix, ch_beats   job geometry
//            strm                A/B/O streams (slave modport)
//            busy                high from the cycle after start to done
//            done                one-cycle pulse after the last handoff
//            err                 one-cycle pulse on a rejected start
// Revision : 1.0 - initial release
// ============================================================================
module eltwise_stream_unit #(
    parameter int TOUT    = 32,
    parameter int DW      = 16,
    parameter int FRAC    = 8,
    parameter int B_DEPTH = 128,
    parameter int CNT_W   = 24
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               start,
    input  wire  [2:0]        mode,
    input  wire  [1:0]        b_bcast,
    input  wire  [CNT_W-1:0]  num_pix,
    input  wire  [CNT_W-1:0]  ch_beats,
    eltwise_stream_unit_if.slave strm,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               c_W     = TOUT * DW;
    localparam int               c_IDX_W = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(B_DEPTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD_S = 3'd1;
    localparam logic [2:0] c_ST_LOAD_C = 3'd2;
    localparam logic [2:0] c_ST_RUN    = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;

    logic [2:0]       r_mode;
    logic [1:0]       r_bcast;
    logic [CNT_W-1:0] r_num_pix;
    logic [CNT_W-1:0] r_ch_beats;
    logic [CNT_W-1:0] r_beat;
    logic [CNT_W-1:0] r_pix;
    logic [DW-1:0]    r_scalar;
    logic [c_W-1:0]   r_buf [B_DEPTH];

    logic             r_o_valid;
    logic             r_o_last;
    logic [c_W-1:0]   r_o_data;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_cfg_bad;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_slot_free;
    logic             w_a_ready;
    logic             w_b_ready;
    logic             w_a_fire;
    logic             w_b_fire;
    logic             w_beat_wrap;
    logic             w_last_acc;
    logic [c_W-1:0]   w_b_beat;
    logic [c_W-1:0]   w_result;

    // Clamp a wide signed value into DW bits: it fits only when the top
    // DW+1 bits are all copies of the sign.
    function automatic logic [DW-1:0] f_sat(input logic [2*DW-1:0] v);
        if ((&v[2*DW-1:DW-1]) || !(|v[2*DW-1:DW-1]))
            return v[DW-1:0];
        else if (v[2*DW-1])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

    // ------------------------------------------------------------------
    // Start qualification
    // ------------------------------------------------------------------
    assign w_cfg_bad = (num_pix == '0) || (ch_beats == '0) || (mode > 3'd4) ||
                       (b_bcast == 2'd3) ||
                       ((b_bcast == 2'd2) && (ch_beats > c_DEPTH));
    assign w_start_ok  = start && (r_state == c_ST_IDLE) && !w_cfg_bad;
    assign w_start_bad = start && (r_state == c_ST_IDLE) &&  w_cfg_bad;

    // A new result may be loaded when the output register is empty or is
    // being drained on this same edge.
    assign w_slot_free = !r_o_valid || strm.o_ready;
    assign w_a_fire    = strm.a_valid && w_a_ready;
    assign w_b_fire    = strm.b_valid && w_b_ready;
    assign w_beat_wrap = (r_beat == (r_ch_beats - c_ONE));
    assign w_last_acc  = w_beat_wrap && (r_pix == (r_num_pix - c_ONE));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok) begin
                    case (b_bcast)
                        2'd1:    w_next_state = c_ST_LOAD_S;
                        2'd2:    w_next_state = c_ST_LOAD_C;
                        default: w_next_state = c_ST_RUN;
                    endcase
                end
            end
            c_ST_LOAD_S: if (w_b_fire)                w_next_state = c_ST_RUN;
            c_ST_LOAD_C: if (w_b_fire && w_beat_wrap) w_next_state = c_ST_RUN;
            c_ST_RUN:    if (w_a_fire && w_last_acc)  w_next_state = c_ST_DRAIN;
            c_ST_DRAIN:  if (r_o_valid && strm.o_ready) w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
        case (r_state)
            c_ST_LOAD_S, c_ST_LOAD_C: w_b_ready = 1'b1;
            c_ST_RUN: begin
                if (r_bcast == 2'd0) begin
                    // A and B pair up: each side waits for the other.
                    w_a_ready = w_slot_free && strm.b_valid;
                    w_b_ready = w_slot_free && strm.a_valid;
                end else begin
                    w_a_ready = w_slot_free;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // B operand selection
    // ------------------------------------------------------------------
    always_comb begin
        case (r_bcast)
            2'd1:    w_b_beat = {TOUT{r_scalar}};
            2'd2:    w_b_beat = r_buf[r_beat[c_IDX_W-1:0]];
            default: w_b_beat = strm.b_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-lane arithmetic
    // ------------------------------------------------------------------
    for (genvar l = 0; l < TOUT; l++) begin : g_lane
        logic signed [DW-1:0]   w_a;
        logic signed [DW-1:0]   w_b;
        logic signed [2*DW-1:0] w_ax;
        logic signed [2*DW-1:0] w_bx;
        logic signed [2*DW-1:0] w_prod;
        logic signed [2*DW-1:0] w_res;

        assign w_a    = strm.a_data[l*DW +: DW];
        assign w_b    = w_b_beat[l*DW +: DW];
        assign w_ax   = {{DW{w_a[DW-1]}}, w_a};
        assign w_bx   = {{DW{w_b[DW-1]}}, w_b};
        assign w_prod = w_ax * w_bx;

        always_comb begin
            case (r_mode)
                3'd0:    w_res = w_ax + w_bx;
                3'd1:    w_res = w_ax - w_bx;
                3'd2:    w_res = w_prod >>> FRAC;   // floors toward -inf
                3'd3:    w_res = (w_a > w_b) ? w_ax : w_bx;
                3'd4:    w_res = (w_a < w_b) ? w_ax : w_bx;
                default: w_res = w_ax;
            endcase
        end

        assign w_result[l*DW +: DW] = f_sat(w_res);
    end

    // ------------------------------------------------------------------
    // Configuration, counters, output register, status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= '0;
            r_bcast    <= '0;
            r_num_pix  <= '0;
            r_ch_beats <= '0;
            r_beat     <= '0;
            r_pix      <= '0;
            r_scalar   <= '0;
            r_o_valid  <= 1'b0;
            r_o_last   <= 1'b0;
            r_o_data   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_start_bad;

            if (w_start_ok) begin
                r_mode     <= mode;
                r_bcast    <= b_bcast;
                r_num_pix  <= num_pix;
                r_ch_beats <= ch_beats;
                r_beat     <= '0;
                r_pix      <= '0;
                r_busy     <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end

            if ((r_state == c_ST_LOAD_S) && w_b_fire)
                r_scalar <= strm.b_data[DW-1:0];

            // The beat counter doubles as the buffer write index while loading.
            if ((r_state == c_ST_LOAD_C) && w_b_fire)
                r_beat <= w_beat_wrap ? '0 : r_beat + c_ONE;

            if (w_a_fire) begin
                if (w_beat_wrap) begin
                    r_beat <= '0;
                    r_pix  <= r_pix + c_ONE;
                end else begin
                    r_beat <= r_beat + c_ONE;
                end
                r_o_valid <= 1'b1;
                r_o_data  <= w_result;
                r_o_last  <= w_last_acc;
            end else if (strm.o_ready) begin
                r_o_valid <= 1'b0;
                r_o_last  <= 1'b0;
            end

            if ((r_state == c_ST_DRAIN) && r_o_valid && strm.o_ready)
                r_done <= 1'b1;
        end
    end

    // Broadcast buffer: contents need no reset.
    always_ff @(posedge clk) begin
        if ((r_state == c_ST_LOAD_C) && w_b_fire)
            r_buf[r_beat[c_IDX_W-1:0]] <= strm.b_data;
    end

    assign strm.a_ready = w_a_ready;
    assign strm.b_ready = w_b_ready;
    assign strm.o_valid = r_o_valid;
    assign strm.o_data  = r_o_data;
    assign strm.o_last  = r_o_last;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: doc/eltwise_stream_unit.md
Name: eltwise_stream_unit

Overview:
- Parametrised streaming element-wise engine for the HBM accelerator datapath; successor to the fixed add/minus/mul element-wise block.
- Combines operand stream A with operand stream B, TOUT lanes per beat, over a feature map of num_pix pixels × ch_beats channel beats.
- Adds max/min modes, signed saturation, fixed-point multiply and B-broadcast modes (scalar, per-channel).
- Sits between the DMA read streams and the write-back stream.

Parameters:
- TOUT, 32, lanes per beat.
- DW, 16, signed two's-complement lane width.
- FRAC, 8, fractional bits; the multiply result is shifted right arithmetically by FRAC.
- B_DEPTH, 128, beats held in the per-channel broadcast buffer.
- CNT_W, 24, width of the pixel and beat counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; configuration is sampled on this cycle
- mode  in  3  0 add, 1 sub (A−B), 2 mul, 3 max, 4 min, 5–7 reserved
- b_bcast  in  2  0 element-wise, 1 scalar (lane 0 of first B beat), 2 per-channel, 3 reserved
- num_pix  in  CNT_W  pixel count (H*W)
- ch_beats  in  CNT_W  channel beats per pixel (CH div Tout)
- a_valid  in  1
- a_ready  out  1
- a_data  in  TOUT*DW
- b_valid  in  1
- b_ready  out  1
- b_data  in  TOUT*DW
- o_valid  out  1
- o_ready  in  1
- o_data  out  TOUT*DW
- o_last  out  1  marks the final beat of the job
- busy  out  1
- done  out  1  one-cycle pulse
- err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset: state IDLE; counters at 0; o_valid, o_last, busy, done, err, a_ready, b_ready all 0; o_data 0. Reset mid-job aborts immediately with no done pulse. Broadcast-buffer contents are don't-care after reset.
- States: IDLE, LOAD_S, LOAD_C, RUN, DRAIN.
- start in IDLE with any of the following pulses err for 1 cycle and stays in IDLE: num_pix=0, ch_beats=0, mode>4, b_bcast=3, or (b_bcast=2 and ch_beats>B_DEPTH).
- Otherwise start moves IDLE to LOAD_S (b_bcast=1), LOAD_C (b_bcast=2) or RUN (b_bcast=0). busy=1 from the next cycle until the done cycle inclusive.
- start outside IDLE is ignored.
- LOAD_S: b_ready=1. The first B handshake latches lane 0 as the scalar, then the state moves to RUN.
- LOAD_C: b_ready=1. Each B handshake writes buf[idx++]; after ch_beats writes the state moves to RUN.
- RUN: slot_free = !o_valid || o_ready.
  - b_bcast=0: a_ready = slot_free && b_valid; b_ready = slot_free && a_valid. A and B are consumed on the same cycle.
  - b_bcast≠0: a_ready = slot_free; b_ready = 0. The B operand is the scalar or buf[beat].
  - No ready depends combinationally on o_valid's source; valid never depends on ready.
- Beat counter wraps at ch_beats−1 and increments the pixel counter. The accept of beat (num_pix−1, ch_beats−1) sets o_last with that result and moves the state to DRAIN.
- Latency: a result is registered; o_valid rises the cycle after the accept.
  - o_data and o_last hold while o_valid && !o_ready.
  - Full throughput is 1 beat/cycle under continuous o_ready.
- DRAIN: when the last beat hands off (o_valid && o_ready), done pulses on that cycle edge → IDLE the next cycle. The buffer is retained but not reused across jobs.
- Arithmetic, per lane, in signed DW+1 (add/sub) or 2*DW (mul):
  - add: a+b.
  - sub: a−b.
  - mul: (a*b) >>> FRAC, truncating toward −inf.
  - max / min: signed compare.
  - Every result saturates to [−2^(DW−1), 2^(DW−1)−1].
- Simultaneous events: in the same cycle, o_ready drains the old result while a new accept loads the register. In LOAD_*, A is never accepted.

Test Plan:
- Reset, then num_pix=17, ch_beats=128, mode=0, b_bcast=0 with A=lane index and B=1 → 2176 beats; lane i = i+1; o_last only on beat 2176; exactly one done.
- mode=0, all lanes A=0x7F00, B=0x0200 → every lane 0x7FFF. mode=1, A=0x8000, B=1 → 0x8000 (saturated).
- mode=2, FRAC=8, A=0x0180 (1.5), B=0xFF00 (−1.0) → 0xFE80. A=0x7FFF, B=0x7FFF → 0x7FFF.
- b_bcast=2, ch_beats=4, B beats k=10,20,30,40, num_pix=3, mode=3, A=25 on every lane → output sequence 25,25,30,40 repeated 3 times; b_ready=0 throughout RUN.
- b_bcast=1, B lane0=−3, mode=4, A=−5 and 7 alternating → −5, −3 alternating. Random o_ready stalls at 50% → no data change while stalled; count preserved.
- Error and abort cases:
  - ch_beats=129 with b_bcast=2 → err pulse, busy stays 0.
  - start during RUN → ignored.
  - rst asserted mid-RUN → all outputs 0 on the next cycle, no done; a fresh job then completes correctly.
